// File: rtl/slt_seq_8bit_pkg.sv
// ---------------------------------------------------------------------------
// slt_seq_8bit_pkg
//   Shared definitions for the bit-serial set-less-than engine: FSM state
//   encodings, the default operand width and the helper that turns the final
//   borrow-out of A-B into a signed or unsigned less-than flag.
// ---------------------------------------------------------------------------
package slt_seq_8bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Unsigned: A<B exactly when A-B borrows out of the MSB.
    // Signed: differing sign bits invert the unsigned ordering, so XOR the
    // borrow with both operand MSBs.
    function automatic logic lt_from_borrow(input logic borrow,
                                            input logic a_msb,
                                            input logic b_msb,
                                            input logic is_signed);
        return is_signed ? (borrow ^ a_msb ^ b_msb) : borrow;
    endfunction

endpackage

// File: rtl/slt_serial_bit.sv
// ---------------------------------------------------------------------------
// slt_serial_bit
//   Combinational 1-bit borrow cell of a serial subtractor computing a_i-b_i.
//   Ports:
//     a_i   in  1  minuend bit
//     b_i   in  1  subtrahend bit
//     bin   in  1  borrow from the less significant bit
//     bout  out 1  borrow into the next more significant bit
// ---------------------------------------------------------------------------
module slt_serial_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin,
    output logic bout
);

    // Borrow is generated when 0-1, and propagated when the bits are equal.
    assign bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);

endmodule

// File: rtl/slt_seq_8bit.sv
// ---------------------------------------------------------------------------
// slt_seq_8bit
//   Multi-cycle set-less-than engine. Accepts {a, b, is_signed} over a
//   valid/ready request channel, walks the operands LSB first through a
//   single borrow cell (one bit per cycle, WIDTH cycles), then presents
//   {WIDTH-1 zeros, lt} over a valid/ready response channel. One transaction
//   in flight; no request is taken while a result is pending.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     in_valid   in   1      request valid
//     in_ready   out  1      engine idle, request can be accepted
//     a          in   WIDTH  operand A
//     b          in   WIDTH  operand B
//     is_signed  in   1      1 = two's complement compare, 0 = unsigned
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer accepts the result
//     result     out  WIDTH  {WIDTH-1 zeros, lt}
// ---------------------------------------------------------------------------
module slt_seq_8bit
    import slt_seq_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_msb;
    logic             b_msb;
    logic             signed_q;
    logic             borrow;
    logic             borrow_next;
    logic             last_bit;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign last_bit  = (cnt == CNT_LAST);

    slt_serial_bit u_bit (
        .a_i  (a_sh[0]),
        .b_i  (b_sh[0]),
        .bin  (borrow),
        .bout (borrow_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_bit)  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // NOTE: these are discrete flops, not a memory, so resetting them is
    // cheap and keeps result at zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            signed_q <= 1'b0;
            borrow   <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        signed_q <= is_signed;
                        cnt      <= '0;
                        borrow   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_ONE;
                    borrow <= borrow_next;
                    // Capture the result on the MSB cycle so it is already
                    // registered on the first DONE cycle.
                    if (last_bit) begin
                        result <= {{(WIDTH-1){1'b0}},
                                   lt_from_borrow(borrow_next, a_msb, b_msb, signed_q)};
                    end
                end
                ST_DONE: begin
                    if (out_ready) result <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slt_seq_8bit.sv
// ---------------------------------------------------------------------------
// tb_slt_seq_8bit
//   Self-checking bench for slt_seq_8bit: reset, directed compare vectors,
//   exact latency, backpressure and a randomized handshake run against a
//   behavioural '<' reference.
// ---------------------------------------------------------------------------
module tb_slt_seq_8bit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slt_seq_8bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with exact latency checks.
    task automatic run_txn(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic ts, input logic [7:0] exp);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; is_signed = ts; in_valid = 1'b1;
        step();                                  // acceptance edge E
        in_valid  = 1'b0;
        a         = 8'($urandom);                // don't-care after acceptance
        b         = 8'($urandom);
        is_signed = 1'($urandom_range(0, 1));
        for (int k = 1; k < WIDTH; k++) step();  // after edge E+WIDTH-1
        check({tag, " early_valid"}, 32'(out_valid), 32'd0);
        step();                                  // after edge E+WIDTH
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp));
        check({tag, " busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " drained"}, 32'(out_valid), 32'd0);
        check({tag, " cleared"}, 32'(result), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         seen;
        int         got;
        int         cycles;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0;
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Reset mid-RUN drops the transaction.
        a = 8'h00; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("midrun busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midrun in_ready", 32'(in_ready), 32'd1);
        check("midrun out_valid", 32'(out_valid), 32'd0);
        check("midrun result", 32'(result), 32'd0);
        step();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid || !in_ready) seen++;
        end
        check("midrun no_response", 32'(seen), 32'd0);

        // Directed vectors.
        run_txn("u 00<FF", 8'h00, 8'hFF, 1'b0, 8'h01);
        run_txn("u FF<00", 8'hFF, 8'h00, 1'b0, 8'h00);
        run_txn("s 80<7F", 8'h80, 8'h7F, 1'b1, 8'h01);
        run_txn("u 80<7F", 8'h80, 8'h7F, 1'b0, 8'h00);
        run_txn("s FF<00", 8'hFF, 8'h00, 1'b1, 8'h01);
        run_txn("s 00<FF", 8'h00, 8'hFF, 1'b1, 8'h00);
        run_txn("u 5A=5A", 8'h5A, 8'h5A, 1'b0, 8'h00);
        run_txn("s 5A=5A", 8'h5A, 8'h5A, 1'b1, 8'h00);
        run_txn("u 7F<80", 8'h7F, 8'h80, 1'b0, 8'h01);
        run_txn("s 05<06", 8'h05, 8'h06, 1'b1, 8'h01);

        // Backpressure in DONE with a competing request held high.
        a = 8'h80; b = 8'h7F; is_signed = 1'b1; in_valid = 1'b1;
        step();
        a = 8'h10; b = 8'h20; is_signed = 1'b0;  // next request, held throughout
        for (int k = 0; k < WIDTH; k++) step();
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp result", 32'(result), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("bp held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        step();                                  // second request accepted here
        in_valid = 1'b0;
        for (int k = 1; k < WIDTH; k++) step();
        check("bp2 early_valid", 32'(out_valid), 32'd0);
        step();
        check("bp2 out_valid", 32'(out_valid), 32'd1);
        check("bp2 result", 32'(result), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Random pairs with random handshakes against a '<' reference.
        got = 0;
        cycles = 0;
        while (got < 1000 && cycles < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            b         = 8'($urandom);
            is_signed = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            if (in_valid && in_ready)
                exp_q.push_back(is_signed ? {7'b0, $signed(a) < $signed(b)} : {7'b0, a < b});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand duplicate", 32'd1, 32'd0);
                end else begin
                    check("rand result", 32'(result), 32'(exp_q.pop_front()));
                    got++;
                end
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand count", 32'(got), 32'd1000);
        check("rand pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
